// File: rtl/mul_pipe.sv
// mul_pipe: radix-4 Booth multiplier with carry-save reduction; MADD/MSUB under MUL_PIPE_ACC_EN.
// 3-cycle latency, 1 op/cycle; out_ready low freezes every stage and drops in_ready.
module mul_pipe #(
  parameter int WIDTH = 32,  // even, >= 8
  parameter int TAG_W = 4
) (
  input  logic               mul_clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [2*WIDTH-1:0] in_acc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int RW  = 2*WIDTH;
  localparam int XW  = WIDTH + 2;
  localparam int PPW = WIDTH + 3;
  localparam int NPP = WIDTH/2 + 1;

  logic advance;
  logic accept;
  logic s1_vld;
  logic s2_vld;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = s1_vld || s2_vld || out_valid;

  // Booth recoding of the extended multiplier
  logic [XW-1:0]  x_ext;
  logic [XW-1:0]  y_ext;
  logic [XW:0]    y_dig;
  logic [PPW-1:0] pp_x1;
  logic [PPW-1:0] pp_x2;
  logic [PPW-1:0] pp_d [NPP];
  logic [NPP-1:0] neg_d;

  assign x_ext = {{2{in_signed & in_x[WIDTH-1]}}, in_x};
  assign y_ext = {{2{in_signed & in_y[WIDTH-1]}}, in_y};
  assign y_dig = {y_ext, 1'b0};
  assign pp_x1 = {x_ext[XW-1], x_ext};
  assign pp_x2 = {x_ext, 1'b0};

  // Negative digits are emitted as one's complement plus a carry-in bit
  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      pp_d[i]  = '0;
      neg_d[i] = 1'b0;
      case (y_dig[2*i +: 3])
        3'b001, 3'b010: pp_d[i] = pp_x1;
        3'b011:         pp_d[i] = pp_x2;
        3'b100: begin
          pp_d[i]  = ~pp_x2;
          neg_d[i] = 1'b1;
        end
        3'b101, 3'b110: begin
          pp_d[i]  = ~pp_x1;
          neg_d[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [PPW-1:0]   s1_pp [NPP];
  logic [NPP-1:0]   s1_neg;
  logic [TAG_W-1:0] s1_tag;
  logic [RW-1:0]    s2_sum;
  logic [RW-1:0]    s2_carry;
  logic [TAG_W-1:0] s2_tag;

  // Partial products aligned to their digit weight, carries gathered into one extra row
  logic [RW-1:0] rows [NPP+1];
  logic [RW-1:0] csa_sum;
  logic [RW-1:0] csa_carry;
  logic [RW-1:0] csa_t;

  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      rows[i] = {{(RW-PPW){s1_pp[i][PPW-1]}}, s1_pp[i]} << (2*i);
    end
    rows[NPP] = '0;
    for (int i = 0; i < NPP; i++) begin
      rows[NPP][2*i] = s1_neg[i];
    end
    csa_sum   = rows[0];
    csa_carry = rows[1];
    csa_t     = '0;
    for (int i = 2; i <= NPP; i++) begin
      csa_t     = csa_sum ^ csa_carry ^ rows[i];
      csa_carry = ((csa_sum & csa_carry) | (csa_sum & rows[i]) | (csa_carry & rows[i])) << 1;
      csa_sum   = csa_t;
    end
  end

  logic [RW-1:0] s3_prod;
  logic [RW-1:0] s3_result;

  assign s3_prod = s2_sum + s2_carry;

`ifdef MUL_PIPE_ACC_EN
  typedef struct packed {
    logic [1:0]    op;
    logic [RW-1:0] acc;
  } acc_t;

  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;

  acc_t s1_acc;
  acc_t s2_acc;

  always_comb begin
    case (s2_acc.op)
      OP_MADD: s3_result = s2_acc.acc + s3_prod;
      OP_MSUB: s3_result = s2_acc.acc + ~s3_prod + RW'(1);
      default: s3_result = s3_prod;
    endcase
  end

  always_ff @(posedge mul_clk) begin
    if (advance) begin
      s1_acc <= '{op: in_op, acc: in_acc};
      s2_acc <= s1_acc;
    end
  end
`else
  logic unused_acc_inputs;

  assign unused_acc_inputs = ^{in_op, in_acc};
  assign s3_result         = s3_prod;
`endif

  // Datapath registers: no reset, qualified by the stage valid bits
  always_ff @(posedge mul_clk) begin
    if (advance) begin
      s1_pp    <= pp_d;
      s1_neg   <= neg_d;
      s1_tag   <= in_tag;
      s2_sum   <= csa_sum;
      s2_carry <= csa_carry;
      s2_tag   <= s1_tag;
    end
  end

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      s1_vld    <= accept;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_result <= s3_result;
        out_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: directed corner ops, stall/flush/reset scenarios and random traffic
// scored against an arithmetic reference model with an in-order expectation queue.
module tb_mul_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int RW = 2*W;
`ifdef MUL_PIPE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          mul_clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [1:0]    in_op;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_y;
  logic [RW-1:0] in_acc;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_acc     (in_acc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 mul_clk = ~mul_clk;

  typedef struct {
    logic [RW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   n_retired = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] ref_result(input logic sg, input logic [1:0] op,
                                               input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [RW-1:0] acc);
    logic [RW-1:0] xe;
    logic [RW-1:0] ye;
    logic [RW-1:0] p;
    xe = {{W{sg & x[W-1]}}, x};
    ye = {{W{sg & y[W-1]}}, y};
    p  = xe * ye;
    if (ACC_EN && op == 2'b01) return acc + p;
    if (ACC_EN && op == 2'b10) return acc - p;
    return p;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: every presented result must match the oldest outstanding op
  always @(negedge mul_clk) begin
    if (out_valid) begin
      chk("result_pending", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        chk("result", 128'(out_result), 128'(sb[0].res));
        chk("tag", 128'(out_tag), 128'(sb[0].tag));
        if (out_ready) begin
          void'(sb.pop_front());
          n_retired++;
        end
      end
    end
    if (flush || reset) sb.delete();
    if (in_valid && in_ready)
      sb.push_back('{res: ref_result(in_signed, in_op, in_x, in_y, in_acc), tag: in_tag});
  end

  task automatic step();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic drive(input logic sg, input logic [1:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [RW-1:0] acc, input logic [TW-1:0] tag);
    in_valid  = 1'b1;
    in_signed = sg;
    in_op     = op;
    in_x      = x;
    in_y      = y;
    in_acc    = acc;
    in_tag    = tag;
  endtask

  task automatic run_one(input string name, input logic sg, input logic [1:0] op,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [RW-1:0] acc,
                         input logic [TW-1:0] tag, input logic [RW-1:0] exp_res);
    int cnt;
    drive(sg, op, x, y, acc, tag);
    @(negedge mul_clk);
    chk({name, "_accept"}, 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge mul_clk);
      cnt++;
    end while (!out_valid && cnt < 10);
    chk({name, "_latency"}, 128'(cnt), 128'(3));
    chk({name, "_res"}, 128'(out_result), 128'(exp_res));
    chk({name, "_tag"}, 128'(out_tag), 128'(tag));
    step();
  endtask

  initial begin
    int r0;
    int cnt;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_op     = 2'b00;
    in_x      = '0;
    in_y      = '0;
    in_acc    = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge mul_clk);
    @(negedge mul_clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_result", 128'(out_result), 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    step();
    reset = 1'b0;
    @(negedge mul_clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    step();

    run_one("u_ffff", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 4'h5, 64'hFFFF_FFFE_0000_0001);
    run_one("s_m1x2", 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, '0, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_one("u_m1x2", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, '0, 4'h2, 64'h0000_0001_FFFF_FFFE);
    run_one("s_min2", 1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, '0, 4'h3, 64'h4000_0000_0000_0000);
    run_one("op11", 1'b1, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 64'h1234, 4'h4, 64'hFFFF_FFFF_FFFF_FFEB);
    run_one("madd", 1'b0, 2'b01, 32'd3, 32'd5, 64'h0000_0001_0000_0000, 4'h6,
            ACC_EN ? 64'h0000_0001_0000_000F : 64'h0000_0000_0000_000F);
    run_one("msub", 1'b0, 2'b10, 32'd1, 32'd1, 64'h0, 4'h7,
            ACC_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_0001);

    // Four back-to-back ops, then a two-cycle consumer stall
    out_ready = 1'b1;
    r0 = n_retired;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 2'b00, W'($urandom), W'($urandom), {$urandom, $urandom}, TW'(i));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge mul_clk);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      step();
    end
    out_ready = 1'b1;
    cnt = 0;
    while (busy && cnt < 20) begin
      step();
      cnt++;
    end
    chk("stall_delivered", 128'(n_retired - r0), 128'(4));

    // Flush with two ops in flight and a new request pending
    r0 = n_retired;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, W'($urandom), W'($urandom), '0, TW'(8 + i));
      step();
    end
    drive(1'b0, 2'b00, 32'd9, 32'd9, '0, 4'hA);
    flush = 1'b1;
    @(negedge mul_clk);
    chk("flush_in_ready", 128'(in_ready), 128'(0));
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge mul_clk);
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    repeat (4) @(negedge mul_clk);
    step();
    chk("flush_none_retired", 128'(n_retired - r0), 128'(0));
    run_one("post_flush", 1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3, '0, 4'hB, 64'hFFFF_FFFF_FFFF_FFFA);

    // Reset with all three stages occupied
    out_ready = 1'b0;
    r0 = n_retired;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, W'($urandom), W'($urandom), '0, TW'(12 + i));
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge mul_clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_full", 128'(out_valid), 128'(1));
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge mul_clk);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_result", 128'(out_result), 128'(0));
    chk("midrst_out_tag", 128'(out_tag), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready_after", 128'(in_ready), 128'(1));
    repeat (4) @(negedge mul_clk);
    step();
    chk("midrst_none_retired", 128'(n_retired - r0), 128'(0));
    run_one("post_reset", 1'b0, 2'b00, 32'd100000, 32'd100000, '0, 4'hF, 64'h0000_0002_540B_E400);

    // Random traffic with consumer backpressure and occasional flushes
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_signed = 1'($urandom);
      in_op     = 2'($urandom);
      in_x      = pick_operand();
      in_y      = pick_operand();
      in_acc    = {$urandom, $urandom};
      in_tag    = TW'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 40) == 0;
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while ((sb.size() > 0 || busy) && cnt < 50) begin
      step();
      cnt++;
    end
    chk("final_drain", 128'(sb.size()), 128'(0));
    chk("final_busy", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
